// File: rtl/array_heap_pkg.sv
// Shared types and helpers for the multi-array heap engine.
package array_heap_pkg;

  typedef enum logic [2:0] {
    OP_ALLOC = 3'd0,
    OP_FREE  = 3'd1,
    OP_PUSH  = 3'd2,
    OP_POP   = 3'd3,
    OP_READ  = 3'd4,
    OP_WRITE = 3'd5,
    OP_SIZE  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_OK         = 3'd0,
    ST_NO_ARRAY   = 3'd1,
    ST_OVERFLOW   = 3'd2,
    ST_UNDERFLOW  = 3'd3,
    ST_ILLEGAL_OP = 3'd4
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Handle width: at least one bit even for a single array.
  function automatic int calc_aw(input int n_arrays);
    return (n_arrays > 1) ? $clog2(n_arrays) : 1;
  endfunction

  // Index/size width: must be able to hold the value N_AREA itself.
  function automatic int calc_iw(input int n_area);
    return $clog2(n_area + 1);
  endfunction

endpackage

// File: rtl/array_heap_ram.sv
// 1R1W synchronous element store with registered read data.
module array_heap_ram #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 32,
  parameter int RAW   = 5
) (
  input  logic             clock,
  input  logic             we,
  input  logic [RAW-1:0]   waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [RAW-1:0]   raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port: contents are never reset.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: data is held until the next read enable.
  always_ff @(posedge clock) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/array_heap_unit.sv
// Multi-array heap engine: handle allocation with a recycled-handle free
// stack, per-array size tracking, bounds checking and a 3-state command FSM.
//
// Handshakes: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. rsp_data
// and rsp_status stay stable while rsp_valid is high and rsp_ready is low.
module array_heap_unit
  import array_heap_pkg::*;
#(
  parameter int WIDTH    = 12,
  parameter int N_ARRAYS = 4,
  parameter int N_AREA   = 8,
  localparam int AW = calc_aw(N_ARRAYS),
  localparam int IW = calc_iw(N_AREA)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [AW-1:0]    req_array,
  input  logic [IW-1:0]    req_index,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       rsp_status,
  output logic [1:0]       dbg_state
);

  localparam int CW    = $clog2(N_ARRAYS + 1);
  localparam int DEPTH = N_ARRAYS * N_AREA;
  localparam int RAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [IW-1:0] AREA_FULL = IW'(N_AREA);
  localparam logic [CW-1:0] NARR_C    = CW'(N_ARRAYS);
  localparam logic [AW:0]   NARR_H    = (AW + 1)'(N_ARRAYS);

  state_e           state;
  op_e              op_q;
  logic [AW-1:0]    arr_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] data_q;

  logic [IW-1:0]       size_r  [N_ARRAYS];
  logic [AW-1:0]       stack_r [N_ARRAYS];
  logic [N_ARRAYS-1:0] alloc_r;
  logic [CW-1:0]       allocs;
  logic [CW-1:0]       top;

  logic [WIDTH-1:0] rsp_data_q;
  logic             rd_sel;
  logic [WIDTH-1:0] ram_rdata;

  status_e          ex_status;
  logic [WIDTH-1:0] ex_data;
  logic             ex_rd;
  logic             ex_we;
  logic             ex_re;
  logic [IW-1:0]    ram_idx;
  logic [RAW-1:0]   ram_addr;
  logic [AW-1:0]    new_handle;
  logic             handle_ok;
  logic [IW-1:0]    cur_size;

  // Decode the latched command into a status, response data and RAM access.
  always_comb begin
    ex_status  = ST_OK;
    ex_data    = '0;
    ex_rd      = 1'b0;
    ex_we      = 1'b0;
    ex_re      = 1'b0;
    ram_idx    = '0;
    new_handle = '0;
    handle_ok  = ({1'b0, arr_q} < NARR_H) && alloc_r[arr_q];
    cur_size   = size_r[arr_q];
    case (op_q)
      OP_ALLOC: begin
        // Recycled handles take priority over fresh ones.
        if (top != '0) new_handle = stack_r[AW'(top - CW'(1))];
        else if (allocs < NARR_C) new_handle = AW'(allocs);
        else ex_status = ST_NO_ARRAY;
        if (ex_status == ST_OK) ex_data = WIDTH'(new_handle);
      end
      OP_RSVD: ex_status = ST_ILLEGAL_OP;
      default: begin
        if (!handle_ok) begin
          ex_status = ST_NO_ARRAY;
        end else begin
          case (op_q)
            OP_PUSH: begin
              if (cur_size == AREA_FULL) ex_status = ST_OVERFLOW;
              else begin
                ram_idx = cur_size;
                ex_we   = 1'b1;
              end
            end
            OP_POP: begin
              if (cur_size == '0) ex_status = ST_UNDERFLOW;
              else begin
                ram_idx = cur_size - IW'(1);
                ex_re   = 1'b1;
                ex_rd   = 1'b1;
              end
            end
            OP_READ: begin
              if (idx_q >= cur_size) ex_status = ST_UNDERFLOW;
              else begin
                ram_idx = idx_q;
                ex_re   = 1'b1;
                ex_rd   = 1'b1;
              end
            end
            OP_WRITE: begin
              if (idx_q >= AREA_FULL) ex_status = ST_OVERFLOW;
              else begin
                ram_idx = idx_q;
                ex_we   = 1'b1;
              end
            end
            OP_SIZE: ex_data = WIDTH'(cur_size);
            default: ex_data = '0;
          endcase
        end
      end
    endcase
    ram_addr = RAW'(int'(arr_q) * N_AREA + int'(ram_idx));
  end

  array_heap_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .RAW   (RAW)
  ) u_ram (
    .clock (clock),
    .we    (ex_we && (state == S_EXEC)),
    .waddr (ram_addr),
    .wdata (data_q),
    .re    (ex_re && (state == S_EXEC)),
    .raddr (ram_addr),
    .rdata (ram_rdata)
  );

  // POP/READ data comes straight from the RAM output register, which holds
  // its value for the whole RESP state.
  assign rsp_data  = rd_sel ? ram_rdata : rsp_data_q;
  assign dbg_state = state;

  // Command FSM plus all heap bookkeeping; everything commits at the EXEC edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data_q <= '0;
      rsp_status <= '0;
      rd_sel     <= 1'b0;
      op_q       <= OP_ALLOC;
      arr_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      alloc_r    <= '0;
      allocs     <= '0;
      top        <= '0;
      for (int i = 0; i < N_ARRAYS; i++) begin
        size_r[i]  <= '0;
        stack_r[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q      <= op_e'(req_op);
            arr_q     <= req_array;
            idx_q     <= req_index;
            data_q    <= req_data;
            req_ready <= 1'b0;
            state     <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_valid  <= 1'b1;
          rsp_status <= ex_status;
          rsp_data_q <= ex_data;
          rd_sel     <= ex_rd;
          if (ex_status == ST_OK) begin
            case (op_q)
              OP_ALLOC: begin
                if (top != '0) top <= top - CW'(1);
                else allocs <= allocs + CW'(1);
                alloc_r[new_handle] <= 1'b1;
                size_r[new_handle]  <= '0;
              end
              OP_FREE: begin
                alloc_r[arr_q]    <= 1'b0;
                stack_r[AW'(top)] <= arr_q;
                top               <= top + CW'(1);
              end
              OP_PUSH: size_r[arr_q] <= cur_size + IW'(1);
              OP_POP:  size_r[arr_q] <= cur_size - IW'(1);
              OP_WRITE: begin
                if (idx_q >= cur_size) size_r[arr_q] <= idx_q + IW'(1);
              end
              default: ;
            endcase
          end
          state <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            rsp_data_q <= '0;
            rsp_status <= '0;
            rd_sel     <= 1'b0;
            req_ready  <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_array_heap_unit.sv
// Self-checking bench for array_heap_unit: a behavioural heap model feeds an
// expected-response queue that is drained as responses come back.
module tb_array_heap_unit;

  localparam int W    = 15;  // {status, data}
  localparam int NA   = 4;
  localparam int AREA = 8;

  logic        clock;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [1:0]  req_array;
  logic [3:0]  req_index;
  logic [11:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [11:0] rsp_data;
  logic [2:0]  rsp_status;
  logic [1:0]  dbg_state;

  array_heap_unit dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_array  (req_array),
    .req_index  (req_index),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_status (rsp_status),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] exp_q[$];

  // Reference model state
  int          m_size  [NA];
  bit          m_alloc [NA];
  int          m_stack [NA];
  int          m_top;
  int          m_allocs;
  logic [11:0] m_mem   [NA*AREA];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) begin
      m_size[i]  = 0;
      m_alloc[i] = 1'b0;
      m_stack[i] = 0;
    end
    m_top    = 0;
    m_allocs = 0;
  endtask

  task automatic model_step(input logic [2:0] op, input int arr, input int idx,
                            input logic [11:0] data, output logic [W-1:0] e);
    logic [2:0]  st;
    logic [11:0] d;
    int          h;
    st = 3'd0;
    d  = 12'd0;
    h  = 0;
    if (op == 3'd7) begin
      st = 3'd4;
    end else if (op == 3'd0) begin
      if (m_top > 0) begin
        m_top = m_top - 1;
        h = m_stack[m_top];
      end else if (m_allocs < NA) begin
        h = m_allocs;
        m_allocs = m_allocs + 1;
      end else begin
        st = 3'd1;
      end
      if (st == 3'd0) begin
        m_alloc[h] = 1'b1;
        m_size[h]  = 0;
        d = 12'(h);
      end
    end else if (!m_alloc[arr]) begin
      st = 3'd1;
    end else begin
      case (op)
        3'd1: begin
          m_alloc[arr]   = 1'b0;
          m_stack[m_top] = arr;
          m_top          = m_top + 1;
        end
        3'd2: begin
          if (m_size[arr] == AREA) st = 3'd2;
          else begin
            m_mem[arr*AREA + m_size[arr]] = data;
            m_size[arr] = m_size[arr] + 1;
          end
        end
        3'd3: begin
          if (m_size[arr] == 0) st = 3'd3;
          else begin
            m_size[arr] = m_size[arr] - 1;
            d = m_mem[arr*AREA + m_size[arr]];
          end
        end
        3'd4: begin
          if (idx >= m_size[arr]) st = 3'd3;
          else d = m_mem[arr*AREA + idx];
        end
        3'd5: begin
          if (idx >= AREA) st = 3'd2;
          else begin
            m_mem[arr*AREA + idx] = data;
            if (idx + 1 > m_size[arr]) m_size[arr] = idx + 1;
          end
        end
        default: d = 12'(m_size[arr]);
      endcase
    end
    e = {st, d};
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n   = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  // Driver: issues one command, optionally holding rsp_ready low for 'hold'
  // cycles once the response appears. Enters and leaves on a falling edge.
  task automatic do_cmd(input logic [2:0] op, input int arr, input int idx,
                        input logic [11:0] data, input int hold);
    logic [W-1:0] e;
    logic [W-1:0] got;
    int           n;
    bit           seen;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (req_ready !== 1'b1) begin
      check("req_ready_timeout", 32'd0, 32'd1);
      return;
    end
    req_valid = 1'b1;
    req_op    = op;
    req_array = 2'(arr);
    req_index = 4'(idx);
    req_data  = data;
    rsp_ready = (hold == 0);
    model_step(op, arr, idx, data, e);
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (rsp_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check("rsp_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
      rsp_ready = 1'b1;
      return;
    end
    got = {rsp_status, rsp_data};
    check($sformatf("op%0d_h%0d_rsp", op, arr), 32'(got), 32'(exp_q.pop_front()));
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge clock);
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_rsp", 32'({rsp_status, rsp_data}), 32'(e));
        check("hold_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
    end
    @(negedge clock);
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_array = 2'd0;
    req_index = 4'd0;
    req_data  = 12'd0;
    rsp_ready = 1'b1;
    model_reset();
    repeat (3) @(negedge clock);

    // Reset values
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_status", 32'(rsp_status), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Give every RAM location a defined value; RAM survives reset.
    for (int a = 0; a < NA; a++) begin
      do_cmd(3'd0, 0, 0, 12'd0, 0);
      for (int i = 0; i < AREA; i++)
        do_cmd(3'd2, a, 0, 12'($urandom_range(0, 4095)), 0);
    end
    do_reset();

    // ALLOC, PUSH 1, PUSH 2, POP, POP, POP underflow, SIZE
    do_cmd(3'd0, 0, 0, 12'd0, 0);
    do_cmd(3'd2, 0, 0, 12'd1, 0);
    do_cmd(3'd2, 0, 0, 12'd2, 0);
    do_cmd(3'd3, 0, 0, 12'd0, 0);
    do_cmd(3'd3, 0, 0, 12'd0, 0);
    do_cmd(3'd3, 0, 0, 12'd0, 0);
    do_cmd(3'd6, 0, 0, 12'd0, 0);
    do_reset();

    // Allocation exhaustion and LIFO handle reuse
    for (int i = 0; i < 5; i++) do_cmd(3'd0, 0, 0, 12'd0, 0);
    do_cmd(3'd1, 2, 0, 12'd0, 0);
    do_cmd(3'd1, 0, 0, 12'd0, 0);
    do_cmd(3'd1, 0, 0, 12'd0, 0);
    do_cmd(3'd0, 0, 0, 12'd0, 0);
    do_cmd(3'd0, 0, 0, 12'd0, 0);
    do_cmd(3'd0, 0, 0, 12'd0, 0);
    do_reset();

    // Sparse WRITE, bounds on READ/WRITE, full array overflow
    do_cmd(3'd0, 0, 0, 12'd0, 0);
    do_cmd(3'd5, 0, 5, 12'h7AB, 0);
    do_cmd(3'd6, 0, 0, 12'd0, 0);
    do_cmd(3'd4, 0, 5, 12'd0, 0);
    do_cmd(3'd4, 0, 6, 12'd0, 0);
    do_cmd(3'd5, 0, 8, 12'h123, 0);
    do_cmd(3'd6, 0, 0, 12'd0, 0);
    do_cmd(3'd0, 0, 0, 12'd0, 0);
    for (int i = 0; i < AREA + 1; i++)
      do_cmd(3'd2, 1, 0, 12'($urandom_range(0, 4095)), 0);
    do_cmd(3'd6, 1, 0, 12'd0, 0);
    do_cmd(3'd4, 1, 7, 12'd0, 0);
    do_cmd(3'd4, 3, 0, 12'd0, 0);
    do_cmd(3'd7, 0, 0, 12'd0, 0);

    // Back-pressure on a data-carrying response
    do_cmd(3'd3, 1, 0, 12'd0, 5);

    // Random command mix
    for (int i = 0; i < 80; i++)
      do_cmd(3'($urandom_range(0, 7)), $urandom_range(0, NA - 1), $urandom_range(0, 9),
             12'($urandom_range(0, 4095)), ($urandom_range(0, 7) == 0) ? 2 : 0);

    // Reset during EXEC discards the command
    while (req_ready !== 1'b1) @(negedge clock);
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_array = 2'd0;
    @(posedge clock);
    #2;
    check("exec_state", 32'(dbg_state), 32'd1);
    reset_n = 1'b0;
    #1;
    req_valid = 1'b0;
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("midrst_hold_valid", 32'(rsp_valid), 32'd0);
    end
    reset_n = 1'b1;
    model_reset();
    @(negedge clock);
    check("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
    do_cmd(3'd0, 0, 0, 12'd0, 0);
    do_cmd(3'd6, 0, 0, 12'd0, 0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
